// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one adder, single-entry registered response stage
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_sum_o,
  output logic                  rsp_carry_o
);
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gid, idx;
  logic             found, can_accept, xfer;
  logic [WIDTH:0]   sum_w;
  assign can_accept  = !rsp_valid_q || rsp_ready_i;
  assign xfer        = rst_n_i && found && can_accept;
  assign req_ready_o = xfer ? NREQ'(1) << gid : '0;
  assign sum_w       = {1'b0, req_a_i[gid*WIDTH +: WIDTH]} + {1'b0, req_b_i[gid*WIDTH +: WIDTH]};
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_carry_o = rsp_carry_q;
  // Search for the first pending requester starting just after the last winner, wrapping around
  always_comb begin
    found = 1'b0;
    gid   = last_q;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end
  // Next response: load on transfer, clear valid on drain-only, otherwise hold
  always_comb begin
    rsp_valid_d = xfer ? 1'b1 : (rsp_ready_i ? 1'b0 : rsp_valid_q);
    rsp_id_d    = xfer ? gid : rsp_id_q;
    rsp_sum_d   = xfer ? sum_w[WIDTH-1:0] : rsp_sum_q;
    rsp_carry_d = xfer ? sum_w[WIDTH] : rsp_carry_q;
    last_d      = xfer ? gid : last_q;
  end
  // Response register and round-robin pointer; reset gives requester 0 top priority
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      last_q      <= IDW'(NREQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      last_q      <= last_d;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter
module tb_adder_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_carry;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  int passed = 0;
  int total  = 0;
  logic [31:0]  held_sum;
  logic [1:0]   held_id;
  adder_arbiter #(.NREQ(4), .WIDTH(32), .IDW(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum), .rsp_carry_o(rsp_carry)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic rsp(input string tag, input logic [1:0] id, input logic [31:0] sum, input logic c);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    chk({tag, "_sum"}, 64'(rsp_sum), 64'(sum));
    chk({tag, "_carry"}, 64'(rsp_carry), 64'(c));
  endtask
  initial begin
    logic [1:0] order [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    #3;
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_sum", 64'(rsp_sum), 64'd0);
    chk("reset_id", 64'(rsp_id), 64'd0);
    chk("reset_carry", 64'(rsp_carry), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    req_valid = 4'h0;
    #5 rst_n = 1'b1;
    tick();
    // single client: requester 2, 5 + 7
    req_a[64 +: 32] = 32'h5; req_b[64 +: 32] = 32'h7; req_valid = 4'b0100;
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'h0;
    rsp("single", 2'd2, 32'hC, 1'b0);
    tick();
    chk("single_drain", 64'(rsp_valid), 64'd0);
    // fresh reset, then all four requesters continuously valid
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(i) * 32'h10;
      req_b[i*32 +: 32] = 32'h1;
    end
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_ready%0d", i), 64'(req_ready), 64'(4'b0001 << order[i]));
      tick();
      rsp($sformatf("rr%0d", i), order[i], 32'(order[i]) * 32'h10 + 32'h1, 1'b0);
    end
    // backpressure with requesters 1 and 3 pending, last grant 1
    rsp_ready = 1'b0; req_valid = 4'b1010;
    held_sum = 32'h11; held_id = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_ready%0d", i), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("bp_sum%0d", i), 64'(rsp_sum), 64'(held_sum));
      chk($sformatf("bp_id%0d", i), 64'(rsp_id), 64'(held_id));
      chk($sformatf("bp_valid%0d", i), 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'b1000);
    tick();
    rsp("bp_release", 2'd3, 32'h31, 1'b0);
    // carry: 0xFFFFFFFF + 1 on requester 0
    req_a[0 +: 32] = 32'hFFFF_FFFF; req_b[0 +: 32] = 32'h1; req_valid = 4'b0001;
    #1 chk("carry1_ready", 64'(req_ready), 64'b0001);
    tick();
    rsp("carry1", 2'd0, 32'h0, 1'b1);
    req_a[32 +: 32] = 32'h8000_0000; req_b[32 +: 32] = 32'h8000_0000; req_valid = 4'b0010;
    #1 chk("carry2_ready", 64'(req_ready), 64'b0010);
    tick();
    rsp("carry2", 2'd1, 32'h0, 1'b1);
    // reset mid-operation with response held and requests 0 and 3 pending
    rsp_ready = 1'b0;
    req_a[0 +: 32] = 32'h100; req_b[0 +: 32] = 32'h23; req_valid = 4'b1001;
    #1 chk("mid_pre_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1 chk("mid_async_valid", 64'(rsp_valid), 64'd0);
    chk("mid_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1 chk("mid_after_ready", 64'(req_ready), 64'b0001);
    tick();
    rsp("mid_after", 2'd0, 32'h123, 1'b0);
    // idle gap: grant 1, idle 5 cycles, then 1 and 2 compete
    req_valid = 4'b0010;
    req_a[32 +: 32] = 32'h40; req_b[32 +: 32] = 32'h2;
    req_a[64 +: 32] = 32'h50; req_b[64 +: 32] = 32'h3;
    #1 chk("idle_first_ready", 64'(req_ready), 64'b0010);
    tick();
    rsp("idle_first", 2'd1, 32'h42, 1'b0);
    req_valid = 4'h0;
    repeat (5) tick();
    chk("idle_empty", 64'(rsp_valid), 64'd0);
    req_valid = 4'b0110;
    #1 chk("idle_ready", 64'(req_ready), 64'b0100);
    tick();
    rsp("idle_win", 2'd2, 32'h53, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 32-bit adder datapath among several requesters in the MIPS core (ALU, branch-target, PC-increment and address-generation clients). Each cycle it picks at most one pending request, performs the addition, and holds the registered sum in a single-entry output stage with a valid/ready handshake. Each response is tagged with the winning requester's index.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width
- IDW, 2, width of requester index; must equal ceil(log2(NREQ))
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  bit i: requester i has operands pending
- req_ready  output  NREQ  bit i: request i accepted this cycle (one-hot or zero)
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- rsp_valid  output  1  result register holds a valid response
- rsp_ready  input  1  consumer takes the response
- rsp_id  output  IDW  index of requester that produced rsp_sum
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH
- rsp_carry  output  1  carry-out, bit WIDTH of a + b

## Operation
- Accept condition: `can_accept = !rsp_valid || rsp_ready`.
- Arbitration (combinational): when can_accept is high, the grant goes to the first i with req_valid[i] set, searching from (last_grant+1) mod NREQ upward with wrap. req_ready has only the winning bit set. When can_accept is low, req_ready is all zero.
- Transfer: a request transfers when req_valid[i] and req_ready[i] are both high. On transfer:
  - rsp_sum and rsp_carry are loaded from the (WIDTH+1)-bit sum of req_a[i] and req_b[i].
  - rsp_id is loaded with i.
  - rsp_valid is set.
  - last_grant is loaded with i.
- last_grant changes only on a transfer. Idle cycles do not rotate priority.
- Drain: if rsp_valid and rsp_ready are high and no transfer occurs, rsp_valid clears. rsp_sum, rsp_id and rsp_carry keep their old values (don't care).
- Simultaneous drain and accept: the new response replaces the old one in the same edge and rsp_valid stays high. Throughput is one addition per cycle.
- Backpressure: while rsp_valid is high and rsp_ready is low, rsp_sum, rsp_id and rsp_carry are held stable and no request is granted.
- Requesters must hold req_valid and operands stable until granted. The arbiter does not latch anything it has not granted.
- Arithmetic is unsigned. Overflow detection for signed operations is the client's job, using the operands and rsp_sum.
- State summary:
  - EMPTY (rsp_valid=0) -> FULL on any transfer.
  - FULL -> EMPTY on drain without transfer.
  - FULL -> FULL on drain with transfer, or on stall.

## Timing
- Latency: a request granted in cycle N appears on rsp_valid/rsp_sum in cycle N+1.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready and last_grant. There is no combinational path from operands to any output.
- Reset values (asynchronous, immediate on rst_n low):
  - rsp_valid = 0, rsp_sum = 0, rsp_carry = 0, rsp_id = 0.
  - last_grant = NREQ-1, so requester 0 has top priority after reset.
  - req_ready = 0 while rst_n is low.
- Reset mid-operation: any pending response is discarded. No grant is issued in a cycle where rst_n is low.
- Wrap-around: after a grant to NREQ-1, the search starts at 0.
- Fairness: a continuously asserted request is granted within NREQ accept cycles.

## Test plan
- Single client: requester 2 sends a=0x0000_0005, b=0x0000_0007 with rsp_ready=1.
  - req_ready=4'b0100 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_sum=0x0000_000C, rsp_id=2, rsp_carry=0.
- All four requesters valid continuously after reset, rsp_ready=1:
  - Grants go 0,1,2,3,0,1 on consecutive cycles.
  - rsp_id follows one cycle later.
  - rsp_valid stays high throughout.
- Backpressure: hold rsp_ready=0 for 3 cycles with a response pending and requesters 1 and 3 valid.
  - req_ready=0 during the stall.
  - rsp_sum and rsp_id stay constant.
  - On the cycle rsp_ready rises, the next requester after last_grant is granted, and the new result appears on the following edge with no bubble.
- Carry/wrap: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_sum=0x0000_0000, rsp_carry=1. Also a=0x8000_0000, b=0x8000_0000 -> rsp_sum=0, rsp_carry=1.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 and requests are pending.
  - rsp_valid drops immediately (without waiting for a clock edge).
  - After release with requesters 0 and 3 valid, requester 0 wins first.
- Idle gap: grant requester 1, then leave all req_valid low for 5 cycles, then assert requesters 1 and 2.
  - Requester 2 wins, because priority did not rotate during the idle cycles.
